// File: rtl/uart_rx_byte.sv
// UART receive front end: 2-flop synchronizer, start-edge detect, and an
// IDLE/START/DATA/PARITY/STOP sampler that delivers one byte plus error flags.
module uart_rx_byte #(
   parameter int BR         = 434,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rx_en,
   output logic [7:0] rx_data,
   output logic       rx_vld,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(BR);
   localparam logic [CW-1:0] BIT_END = CW'(BR - 1);
   localparam logic [CW-1:0] SAMPLE  = CW'(BR / 2);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic          sync1_q, rx_s_q, rx_d_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] br_cnt_q, br_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_vld_q, rx_vld_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic          start_edge, bit_end, sample_pt;

   // Sync flops reset high so a line that is already idle never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         rx_d_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
         rx_d_q  <= rx_s_q;
      end
   end

   assign start_edge = rx_d_q & ~rx_s_q;
   assign bit_end    = (br_cnt_q == BIT_END);
   assign sample_pt  = (br_cnt_q == SAMPLE);

   always_comb begin
      state_d   = state_q;
      br_cnt_d  = br_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      rx_data_d = rx_data_q;
      rx_vld_d  = 1'b0;
      perr_d    = perr_q;
      ferr_d    = ferr_q;

      if (state_q != IDLE) begin
         br_cnt_d = bit_end ? '0 : br_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            br_cnt_d  = '0;
            bit_cnt_d = 3'd0;
            if (rx_en && start_edge) state_d = START;
         end
         START: begin
            if (sample_pt && rx_s_q) state_d = IDLE;
            else if (bit_end)        state_d = DATA;
         end
         DATA: begin
            if (sample_pt) shift_d[bit_cnt_q] = rx_s_q;
            if (bit_end) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d   = PARITY;
                  bit_cnt_d = 3'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (sample_pt) par_d = rx_s_q;
            if (bit_end)   state_d = STOP;
         end
         STOP: begin
            // Leave at mid-stop so a start bit right after the stop bit is caught.
            if (sample_pt) begin
               rx_data_d = shift_q;
               perr_d    = ((^shift_q) ^ par_q) != PARITY_ODD;
               ferr_d    = ~rx_s_q;
               rx_vld_d  = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) br_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         br_cnt_q  <= '0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         par_q     <= 1'b0;
         rx_data_q <= 8'h00;
         rx_vld_q  <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         br_cnt_q  <= br_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         rx_data_q <= rx_data_d;
         rx_vld_q  <= rx_vld_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_vld     = rx_vld_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at BR=16, even parity: frames are driven
// bit by bit on the falling clock edge and every rx_vld pulse is logged.
module tb_uart_rx_byte;

   localparam int BR   = 16;
   localparam int HALF = BR / 2;
   // Pin edge to START entry is 3 cycles; START entry to rx_vld is 10*BR+HALF+1.
   localparam int VLD_LAT = 3 + 10 * BR + HALF + 1;

   logic       clk, rst_n, rx, rx_en;
   logic [7:0] rx_data;
   logic       rx_vld, parity_err, frame_err, busy;

   int errs   = 0;
   int checks = 0;
   int cyc    = 0;

   logic [7:0] obs_data[$];
   logic       obs_perr[$];
   logic       obs_ferr[$];
   int         obs_cyc[$];

   uart_rx_byte #(.BR(BR), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .rx_en(rx_en),
      .rx_data(rx_data), .rx_vld(rx_vld), .parity_err(parity_err),
      .frame_err(frame_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && rx_vld) begin
         obs_data.push_back(rx_data);
         obs_perr.push_back(parity_err);
         obs_ferr.push_back(frame_err);
         obs_cyc.push_back(cyc);
      end
   end

   task automatic clear_obs();
      obs_data.delete();
      obs_perr.delete();
      obs_ferr.delete();
      obs_cyc.delete();
   endtask

   // Called just after a falling edge; leaves rx at the stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             output int t0);
      rx = 1'b0;
      t0 = cyc;
      repeat (BR) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BR) @(negedge clk);
      end
      rx = p;
      repeat (BR) @(negedge clk);
      rx = s;
      repeat (BR) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_frame(input string name, input int idx, input logic [7:0] ed,
                              input logic ep, input logic ef);
      checks++;
      if (obs_data.size() <= idx) begin
         errs++;
         $display("FAIL %s: pulse %0d missing, got %0d pulses", name, idx, obs_data.size());
      end else begin
         if (obs_data[idx] !== ed) begin
            errs++;
            $display("FAIL %s data: got %h want %h", name, obs_data[idx], ed);
         end
         checks++;
         if (obs_perr[idx] !== ep) begin
            errs++;
            $display("FAIL %s parity_err: got %b want %b", name, obs_perr[idx], ep);
         end
         checks++;
         if (obs_ferr[idx] !== ef) begin
            errs++;
            $display("FAIL %s frame_err: got %b want %b", name, obs_ferr[idx], ef);
         end
      end
   endtask

   task automatic check_count(input string name, input int want);
      checks++;
      if (obs_data.size() != want) begin
         errs++;
         $display("FAIL %s pulse count: got %0d want %0d", name, obs_data.size(), want);
      end
   endtask

   task automatic check_outputs_reset(input string name);
      checks++;
      if ({rx_data, rx_vld, parity_err, frame_err, busy} !== 12'h000) begin
         errs++;
         $display("FAIL %s: data=%h vld=%b perr=%b ferr=%b busy=%b want all 0",
                  name, rx_data, rx_vld, parity_err, frame_err, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx    = 1'b1;
      rx_en = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_reset("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_outputs_reset("after_reset_idle");
   endtask

   task automatic test_basic();
      int t0;
      clear_obs();
      send_frame(8'hA5, 1'b0, 1'b1, t0);
      check_count("basic", 1);
      check_frame("basic", 0, 8'hA5, 1'b0, 1'b0);
      checks++;
      if (obs_cyc.size() > 0 && obs_cyc[0] != t0 + VLD_LAT) begin
         errs++;
         $display("FAIL basic latency: got %0d want %0d", obs_cyc[0] - t0, VLD_LAT);
      end
      checks++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL basic busy_after: got %b want 0", busy);
      end
      idle(10);
   endtask

   task automatic test_parity_err();
      int t0;
      clear_obs();
      send_frame(8'h01, 1'b0, 1'b1, t0);
      check_count("parity", 1);
      check_frame("parity", 0, 8'h01, 1'b1, 1'b0);
      idle(10);
   endtask

   task automatic test_frame_err();
      int t0;
      clear_obs();
      send_frame(8'h3C, 1'b0, 1'b0, t0);
      repeat (40) @(negedge clk);
      check_count("frame_low_hold", 1);
      check_frame("frame_err", 0, 8'h3C, 1'b0, 1'b1);
      idle(20);
      send_frame(8'h55, 1'b0, 1'b1, t0);
      check_count("frame_recover", 2);
      check_frame("frame_recover", 1, 8'h55, 1'b0, 1'b0);
      idle(10);
   endtask

   task automatic test_glitch();
      int busy_cnt;
      clear_obs();
      busy_cnt = 0;
      rx = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 3) rx = 1'b1;
         if (busy) busy_cnt++;
      end
      checks++;
      if (busy_cnt != HALF + 1) begin
         errs++;
         $display("FAIL glitch busy cycles: got %0d want %0d", busy_cnt, HALF + 1);
      end
      check_count("glitch", 0);
      checks++;
      if ({rx_data, parity_err, frame_err} !== {8'h55, 2'b00}) begin
         errs++;
         $display("FAIL glitch hold: data=%h perr=%b ferr=%b want 55 0 0",
                  rx_data, parity_err, frame_err);
      end
   endtask

   task automatic test_back_to_back();
      int t0, t1;
      clear_obs();
      send_frame(8'h00, 1'b0, 1'b1, t0);
      send_frame(8'hFF, 1'b0, 1'b1, t1);
      idle(10);
      check_count("b2b", 2);
      check_frame("b2b_first", 0, 8'h00, 1'b0, 1'b0);
      check_frame("b2b_second", 1, 8'hFF, 1'b0, 1'b0);
      checks++;
      if (obs_cyc.size() > 1 && obs_cyc[1] != t1 + VLD_LAT) begin
         errs++;
         $display("FAIL b2b latency: got %0d want %0d", obs_cyc[1] - t1, VLD_LAT);
      end
      rx_en = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1, t0);
      idle(20);
      check_count("rx_en_off", 2);
      checks++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL rx_en_off busy: got %b want 0", busy);
      end
      rx_en = 1'b1;
   endtask

   task automatic test_en_midframe();
      int t0;
      clear_obs();
      fork
         send_frame(8'h12, 1'b0, 1'b1, t0);
         begin
            repeat (40) @(negedge clk);
            rx_en = 1'b0;
            checks++;
            if (busy !== 1'b1) begin
               errs++;
               $display("FAIL en_midframe busy: got %b want 1", busy);
            end
         end
      join
      idle(10);
      check_count("en_midframe", 1);
      check_frame("en_midframe", 0, 8'h12, 1'b0, 1'b0);
      rx_en = 1'b1;
   endtask

   task automatic test_reset_midframe();
      int t0;
      clear_obs();
      fork
         send_frame(8'h81, 1'b0, 1'b1, t0);
         begin
            repeat (4 * BR + 6) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check_outputs_reset("reset_mid_assert");
         end
      join
      check_outputs_reset("reset_mid_hold");
      rst_n = 1'b1;
      idle(20);
      check_count("reset_mid_nopulse", 0);
      send_frame(8'h7E, 1'b0, 1'b1, t0);
      idle(10);
      check_count("reset_mid_next", 1);
      check_frame("reset_mid_next", 0, 8'h7E, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_err();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_en_midframe();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
